// File: rtl/demux_dist_if.sv
// Handshake bundle for demux_dist: one producer stream in, NUM_OUT lane streams out,
// plus drop reporting. slave = the demux, master = producer and lane consumers.
interface demux_dist_if #(
   parameter int NUM_OUT = 31,
   parameter int DATA_W  = 2,
   parameter int SEL_W   = 5,
   parameter int CNT_W   = 8
);
   logic                        in_valid;
   logic                        in_ready;
   logic [SEL_W-1:0]            in_sel;
   logic [DATA_W-1:0]           in_data;
   logic [NUM_OUT-1:0]          out_valid;
   logic [NUM_OUT-1:0]          out_ready;
   logic [NUM_OUT*DATA_W-1:0]   out_data;
   logic                        drop_pulse;
   logic [CNT_W-1:0]            drop_cnt;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data, drop_pulse, drop_cnt
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data, drop_pulse, drop_cnt
   );
endinterface

// File: rtl/demux_dist.sv
// 1-to-NUM_OUT registered demux with a one-entry slice per lane; out-of-range selects are dropped.
// Optional saturating drop counter enabled by defining DEMUX_DROP_CNT_EN.
module demux_dist #(
   parameter int NUM_OUT = 31,
   parameter int DATA_W  = 2,
   parameter int SEL_W   = 5,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   demux_dist_if.slave bus
);
   localparam logic [SEL_W:0] NUM_OUT_X = (SEL_W + 1)'(NUM_OUT);

   logic                            sel_legal;
   logic                            accept;
   logic [NUM_OUT-1:0]              sel_hit;
   logic [NUM_OUT-1:0]              lane_open;
   logic [NUM_OUT-1:0]              load;
   logic [NUM_OUT-1:0]              valid_q, valid_d;
   logic [NUM_OUT-1:0][DATA_W-1:0]  data_q, data_d;
   logic                            drop_pulse_q, drop_pulse_d;

   assign sel_legal = {1'b0, bus.in_sel} < NUM_OUT_X;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
         assign sel_hit[gi]   = sel_legal && (bus.in_sel == SEL_W'(gi));
         // A full lane can still take a word in the same cycle its consumer drains it.
         assign lane_open[gi] = ~valid_q[gi] | bus.out_ready[gi];
      end
   endgenerate

   assign bus.in_ready = ~sel_legal | (|(sel_hit & lane_open));
   assign accept       = bus.in_valid & bus.in_ready;
   assign load         = {NUM_OUT{accept}} & sel_hit;

   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      drop_pulse_d = accept & ~sel_legal;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (load[i]) begin
            valid_d[i] = 1'b1;
            data_d[i]  = bus.in_data;
         end else if (bus.out_ready[i]) begin
            valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         data_q       <= '0;
         drop_pulse_q <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_data   = data_q;
   assign bus.drop_pulse = drop_pulse_q;

`ifdef DEMUX_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Saturates at all-ones and holds until reset.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_pulse_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.drop_cnt = drop_cnt_q;
`else
   assign bus.drop_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_demux_dist.sv
// Self-checking bench for demux_dist: scoreboard queue of expected lane words,
// one task per scenario. Drop counter expectations follow DEMUX_DROP_CNT_EN.
module tb_demux_dist;
   localparam int NUM_OUT = 31;
   localparam int DATA_W  = 2;
   localparam int SEL_W   = 5;
   localparam int CNT_W   = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   demux_dist_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

   demux_dist #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          lane;
      logic [1:0]  data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   exp_cnt = 0;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   function automatic logic [DATA_W-1:0] lane_data(input int l);
      return bus.out_data[l*DATA_W +: DATA_W];
   endfunction

   function automatic int cnt_expect(input int n);
`ifdef DEMUX_DROP_CNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 5'd3;
      bus.in_data   = 2'b11;
      bus.out_ready = '0;
      step();
      step();
      total++;
      if (bus.out_valid !== '0) begin
         bad++; $display("FAIL reset_valid got=%h want=0", bus.out_valid);
      end
      total++;
      if (bus.out_data !== '0) begin
         bad++; $display("FAIL reset_data got=%h want=0", bus.out_data);
      end
      total++;
      if (bus.drop_cnt !== '0) begin
         bad++; $display("FAIL reset_cnt got=%0d want=0", bus.drop_cnt);
      end
      total++;
      if (bus.drop_pulse !== 1'b0) begin
         bad++; $display("FAIL reset_pulse got=%b want=0", bus.drop_pulse);
      end
      bus.in_valid = 1'b0;
      reset        = 1'b0;
      sb.delete();
      exp_cnt = 0;
      step();
      $display("test_reset: out_valid=%h drop_cnt=%0d", bus.out_valid, bus.drop_cnt);
   endtask

   task automatic test_single();
      exp_t e;
      bus.in_sel   = 5'd5;
      bus.in_data  = 2'b10;
      bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL single_ready got=%b want=1", bus.in_ready);
      end
      sb.push_back('{5, 2'b10});
      step();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== (31'd1 << 5)) begin
         bad++; $display("FAIL single_valid got=%h want=%h", bus.out_valid, 31'd1 << 5);
      end
      e = sb.pop_front();
      total++;
      if (lane_data(e.lane) !== e.data) begin
         bad++; $display("FAIL single_data lane=%0d got=%b want=%b", e.lane, lane_data(e.lane), e.data);
      end
      bus.out_ready[5] = 1'b1;
      step();
      bus.out_ready = '0;
      total++;
      if (bus.out_valid !== '0) begin
         bad++; $display("FAIL single_drain got=%h want=0", bus.out_valid);
      end
      total++;
      if (lane_data(5) !== 2'b10) begin
         bad++; $display("FAIL single_hold_after_drain got=%b want=10", lane_data(5));
      end
      $display("test_single: lane5 data=%b valid=%b", lane_data(5), bus.out_valid[5]);
   endtask

   task automatic test_backpressure();
      exp_t e;
      bus.in_sel   = 5'd12;
      bus.in_data  = 2'b10;
      bus.in_valid = 1'b1;
      sb.push_back('{12, 2'b10});
      step();
      e = sb.pop_front();
      total++;
      if (bus.out_valid[12] !== 1'b1 || lane_data(e.lane) !== e.data) begin
         bad++; $display("FAIL bp_fill valid=%b got=%b want=%b", bus.out_valid[12], lane_data(e.lane), e.data);
      end
      bus.in_data = 2'b01;
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++; $display("FAIL bp_ready_low got=%b want=0", bus.in_ready);
      end
      step();
      total++;
      if (bus.out_valid[12] !== 1'b1 || lane_data(12) !== 2'b10) begin
         bad++; $display("FAIL bp_stall valid=%b got=%b want=10", bus.out_valid[12], lane_data(12));
      end
      bus.out_ready[12] = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_ready_high got=%b want=1", bus.in_ready);
      end
      sb.push_back('{12, 2'b01});
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = '0;
      e = sb.pop_front();
      total++;
      if (bus.out_valid[12] !== 1'b1 || lane_data(e.lane) !== e.data) begin
         bad++; $display("FAIL bp_passthru valid=%b got=%b want=%b", bus.out_valid[12], lane_data(e.lane), e.data);
      end
      bus.out_ready[12] = 1'b1;
      step();
      bus.out_ready = '0;
      $display("test_backpressure: lane12 data=%b valid=%b", lane_data(12), bus.out_valid[12]);
   endtask

   task automatic test_sweep();
      exp_t e;
      logic [SEL_W-1:0] sv;
      bus.out_ready = '0;
      bus.in_valid  = 1'b1;
      for (int s = 0; s < NUM_OUT; s++) begin
         sv          = SEL_W'(s);
         bus.in_sel  = sv;
         bus.in_data = sv[1:0] ^ 2'b11;
         sb.push_back('{s, sv[1:0] ^ 2'b11});
         step();
      end
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== {NUM_OUT{1'b1}}) begin
         bad++; $display("FAIL sweep_valid got=%h want=all", bus.out_valid);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (lane_data(e.lane) !== e.data) begin
            bad++; $display("FAIL sweep_lane%0d got=%b want=%b", e.lane, lane_data(e.lane), e.data);
         end
      end
      bus.out_ready = '1;
      step();
      bus.out_ready = '0;
      total++;
      if (bus.out_valid !== '0) begin
         bad++; $display("FAIL sweep_drain got=%h want=0", bus.out_valid);
      end
      $display("test_sweep: lane12=%b lane13=%b", lane_data(12), lane_data(13));
   endtask

   task automatic test_drops();
      bus.in_sel   = 5'd31;
      bus.in_data  = 2'b11;
      bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL drop_ready got=%b want=1", bus.in_ready);
      end
      exp_cnt++;
      step();
      bus.in_valid = 1'b0;
      total++;
      if (bus.drop_pulse !== 1'b1) begin
         bad++; $display("FAIL drop_pulse got=%b want=1", bus.drop_pulse);
      end
      total++;
      if (int'(bus.drop_cnt) !== cnt_expect(exp_cnt)) begin
         bad++; $display("FAIL drop_cnt1 got=%0d want=%0d", bus.drop_cnt, cnt_expect(exp_cnt));
      end
      step();
      total++;
      if (bus.drop_pulse !== 1'b0) begin
         bad++; $display("FAIL drop_pulse_clear got=%b want=0", bus.drop_pulse);
      end
      bus.in_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (exp_cnt < CNT_MAX) exp_cnt++;
         step();
      end
      bus.in_valid = 1'b0;
      total++;
      if (int'(bus.drop_cnt) !== cnt_expect(exp_cnt)) begin
         bad++; $display("FAIL drop_cnt_sat got=%0d want=%0d", bus.drop_cnt, cnt_expect(exp_cnt));
      end
      total++;
      if (bus.out_valid !== '0) begin
         bad++; $display("FAIL drop_no_store got=%h want=0", bus.out_valid);
      end
      step();
      total++;
      if (int'(bus.drop_cnt) !== cnt_expect(exp_cnt) || bus.drop_pulse !== 1'b0) begin
         bad++; $display("FAIL drop_hold cnt=%0d pulse=%b want cnt=%0d pulse=0", bus.drop_cnt, bus.drop_pulse, cnt_expect(exp_cnt));
      end
      $display("test_drops: drop_cnt=%0d", bus.drop_cnt);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bus.out_ready = '0;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 5'd2;
      bus.in_data   = 2'b01;
      sb.push_back('{2, 2'b01});
      step();
      bus.in_sel  = 5'd7;
      bus.in_data = 2'b10;
      sb.push_back('{7, 2'b10});
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (bus.out_valid[e.lane] !== 1'b1 || lane_data(e.lane) !== e.data) begin
            bad++; $display("FAIL mid_fill lane%0d valid=%b got=%b want=%b", e.lane, bus.out_valid[e.lane], lane_data(e.lane), e.data);
         end
      end
      bus.in_sel  = 5'd9;
      bus.in_data = 2'b11;
      reset       = 1'b1;
      step();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      exp_cnt      = 0;
      total++;
      if (bus.out_valid !== '0 || bus.out_data !== '0) begin
         bad++; $display("FAIL mid_reset valid=%h data=%h want=0", bus.out_valid, bus.out_data);
      end
      total++;
      if (bus.drop_cnt !== '0) begin
         bad++; $display("FAIL mid_reset_cnt got=%0d want=0", bus.drop_cnt);
      end
      bus.in_sel   = 5'd9;
      bus.in_data  = 2'b01;
      bus.in_valid = 1'b1;
      sb.push_back('{9, 2'b01});
      step();
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if (bus.out_valid !== (31'd1 << 9) || lane_data(e.lane) !== e.data) begin
         bad++; $display("FAIL mid_post valid=%h got=%b want=%b", bus.out_valid, lane_data(e.lane), e.data);
      end
      $display("test_reset_mid: lane9 data=%b valid=%h", lane_data(9), bus.out_valid);
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sel    = '0;
      bus.in_data   = '0;
      bus.out_ready = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_sweep();
      test_drops();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
